mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   N-master arbiter and multiplexer in front of the single shared memory port.
//   - Each master presents HTRANS/HADDR/HWRITE/HWDATA and holds them while its stall bit is high.
//   - One transfer is in flight at a time and is held until memory returns PREADY.
//   - Replaces the 2-master combinational mux: parametrised master count and widths, registered grant.
// PARAMETERS
//   NUM_MASTERS  2   number of requesting masters (>=2); index 0 = fixed-priority highest
//   ADDR_W       32  address width
//   DATA_W       32  write-data width
// PORTS
//   HCLK      in   1                   clock; all state changes on rising edge
//   HRESET    in   1                   synchronous, active-low reset
//   HTRANS    in   NUM_MASTERS         per-master transfer request
//   HADDR     in   NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
//   HWRITE    in   NUM_MASTERS         per-master write(1)/read(0)
//   HWDATA    in   NUM_MASTERS*DATA_W  packed write data, master i at [i*DATA_W +: DATA_W]
//   PREADY    in   1                   memory completes current transfer this cycle
//   PSEL      out  1                   transfer in progress on memory port
//   PADDR     out  ADDR_W              address of granted master
//   PWRITE    out  1                   direction of granted master
//   PDATA     out  DATA_W              write data of granted master
//   grant     out  NUM_MASTERS         one-hot registered grant (all-zero when idle)
//   stall     out  NUM_MASTERS         per-master hold: master must keep its request stable
//   HRESET_o  out  1                   HRESET forwarded combinationally to downstream blocks
// BEHAVIOUR
//   - Reset (HRESET==0 at an edge):
//     - state=IDLE, grant=0, PSEL=0, PADDR/PWRITE/PDATA=0, round-robin pointer=0.
//     - Any in-flight transfer is abandoned; PREADY is ignored during reset.
//   - States:
//     - IDLE: PSEL=0, data outputs 0 (never Z).
//       - Any HTRANS high -> pick winner, load grant, go BUSY at the next edge.
//     - BUSY: PSEL=1; PADDR/PWRITE/PDATA = mux of inputs by grant (combinational from registered grant).
//       - PREADY=1 -> transfer completes this cycle.
//         - Re-arbitrate over HTRANS & ~grant; winner -> new grant, stay BUSY (back-to-back, no idle cycle).
//         - No other request -> grant=0, go IDLE.
//       - PREADY=0 -> hold grant and state.
//   - Latency: request in IDLE at cycle n -> PSEL/grant high in cycle n+1; earliest PREADY completion in cycle n+1.
//   - stall[i] = HTRANS[i] & ~(grant[i] & PSEL & PREADY).
//     - High in the request cycle in IDLE; low only in the completion cycle of master i.
//     - stall[i] is also forced low when HRESET==0.
//   - Completing master is excluded from the immediate re-arbitration.
//     - Its next request is considered from the following IDLE or completion point (no starvation of others).
//   - Master dropping HTRANS while granted does not cancel the transfer; the grant holds until PREADY.
//   - PREADY in IDLE: ignored.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN
//     - Defined: round-robin. Winner is the first requester at or after pointer (wrapping NUM_MASTERS-1 -> 0).
//       - Pointer is updated to winner+1 (mod NUM_MASTERS) whenever a grant is loaded.
//     - Undefined: fixed priority, lowest index wins. Pointer logic is absent; grant is otherwise identical.
// STRUCTURE
//   - Package mem_arb_pkg: state localparams ST_IDLE/ST_BUSY; function onehot_to_idx.
//   - Sub-module mem_arb_picker (NUM_MASTERS): request vector + pointer -> one-hot winner.
//     - Purely combinational; holds both the round-robin and fixed-priority variants under the macro.
//   - Top: state/grant/pointer registers, output mux, stall logic.
// TESTING
//   - Reset: HRESET=0 with HTRANS=2'b11 -> grant=0, PSEL=0, PADDR=0, stall=0; release -> grant=01 next cycle.
//   - Single master: HTRANS[1]=1, HADDR1=0x100, PREADY=1 -> cycle+1 PADDR=0x100, stall[1]=0.
//     - Drop request -> IDLE.
//   - Wait states: granted master 0, PREADY low 3 cycles -> PSEL, grant=01, PADDR all stable 3 cycles.
//     - Completion on the 4th cycle.
//   - Contention: HTRANS=2'b11 continuously, PREADY=1.
//     - RR build: grant alternates 01,10,01.
//     - Fixed build: 01,10,01 (exclusion rule), never 01,01.
//   - N=4 RR wrap: pointer=3, HTRANS=4'b1001 -> grant=1000, then 0001.
//   - Mid-transfer reset: BUSY with PREADY=0, HRESET=0 one cycle -> next edge IDLE, grant=0, pointer=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Holds the arbiter state encoding and a one-hot to index conversion.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Upper bound on master count that onehot_to_idx can encode
    localparam int MAX_MASTERS = 32;
    localparam int IDX_MAX_W   = 5;

    // Index of the single set bit of a one-hot vector (0 when the vector is empty)
    function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = idx | (oh[i] ? IDX_MAX_W'(i) : '0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection for the memory-port arbiter.
// Build option ARB_ROUND_ROBIN_EN: when defined, the winner is the first
// requester at or after ptr (wrapping); otherwise the lowest index wins and
// there is no ptr port.
module mem_arb_picker #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
`endif
    output logic [NUM_MASTERS-1:0]         win
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic found_s;

    // Two passes: requesters at or above ptr first, then wrap to the bottom
    always_comb begin
        win     = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found_s && req[i] && (IDX_W'(i) >= ptr)) begin
                win[i]  = 1'b1;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found_s && req[i]) begin
                win[i]  = 1'b1;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
`else
    logic found_s;

    // Fixed priority: lowest index requester wins
    always_comb begin
        win     = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found_s && req[i]) begin
                win[i]  = 1'b1;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// N-master arbiter and multiplexer in front of a single shared memory port.
// One transfer in flight at a time; grant is registered and held until PREADY.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration (default:
// fixed priority, master 0 highest). A completing master is always excluded
// from the back-to-back re-arbitration so others cannot be starved.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_MASTERS-1:0]        HTRANS,
    input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR,
    input  logic [NUM_MASTERS-1:0]        HWRITE,
    input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA,
    input  logic                          PREADY,
    output logic                          PSEL,
    output logic [ADDR_W-1:0]             PADDR,
    output logic                          PWRITE,
    output logic [DATA_W-1:0]             PDATA,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic [NUM_MASTERS-1:0]        stall,
    output logic                          HRESET_o
);

    arb_state_t               state_r;
    logic [NUM_MASTERS-1:0]   grant_r;
    logic                     psel_r;
    logic [NUM_MASTERS-1:0]   arb_req_s;
    logic [NUM_MASTERS-1:0]   pick_s;
    logic                     load_s;
    logic [ADDR_W-1:0]        mux_addr_s;
    logic                     mux_wr_s;
    logic [DATA_W-1:0]        mux_data_s;

    // Requests eligible for arbitration this cycle: all in IDLE, all but the
    // completing master on a completion cycle, none while waiting on memory
    always_comb begin
        arb_req_s = '0;
        case (state_r)
            ST_IDLE: arb_req_s = HTRANS;
            ST_BUSY: begin
                if (PREADY) begin
                    arb_req_s = HTRANS & ~grant_r;
                end else begin
                    arb_req_s = '0;
                end
            end
            default: arb_req_s = '0;
        endcase
        load_s = |arb_req_s;
    end

`ifdef ARB_ROUND_ROBIN_EN
    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     ptr_next_s;
    logic [IDX_MAX_W-1:0] win_idx_s;

    mem_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req (arb_req_s),
        .ptr (ptr_r),
        .win (pick_s)
    );

    // Pointer moves to the slot just after the winner, wrapping at the top
    always_comb begin
        win_idx_s = onehot_to_idx(MAX_MASTERS'(pick_s));
        if (win_idx_s == IDX_MAX_W'(NUM_MASTERS - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_idx_s[IDX_W-1:0] + IDX_W'(1);
        end
    end

    // Round-robin pointer register, advanced whenever a grant is loaded
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            ptr_r <= '0;
        end else if (load_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    mem_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req (arb_req_s),
        .win (pick_s)
    );
`endif

    // Arbitration state machine with registered grant and PSEL
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            psel_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r <= ST_BUSY;
                        grant_r <= pick_s;
                        psel_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                        psel_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (PREADY && load_s) begin
                        state_r <= ST_BUSY;
                        grant_r <= pick_s;
                        psel_r  <= 1'b1;
                    end else if (PREADY) begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                        psel_r  <= 1'b0;
                    end else begin
                        state_r <= ST_BUSY;
                        grant_r <= grant_r;
                        psel_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    psel_r  <= 1'b0;
                end
            endcase
        end
    end

    // AND-OR mux of the granted master's address, direction and data (zero when idle)
    always_comb begin
        mux_addr_s = '0;
        mux_wr_s   = 1'b0;
        mux_data_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            mux_addr_s = mux_addr_s | (HADDR[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_r[i]}});
            mux_wr_s   = mux_wr_s   | (HWRITE[i] & grant_r[i]);
            mux_data_s = mux_data_s | (HWDATA[i*DATA_W +: DATA_W] & {DATA_W{grant_r[i]}});
        end
    end

    assign PSEL     = psel_r;
    assign PADDR    = mux_addr_s;
    assign PWRITE   = mux_wr_s;
    assign PDATA    = mux_data_s;
    assign grant    = grant_r;
    assign stall    = HTRANS & ~(grant_r & {NUM_MASTERS{psel_r & PREADY}}) & {NUM_MASTERS{HRESET}};
    assign HRESET_o = HRESET;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a 2-master instance for reset,
// single-master, wait-state, contention and mid-transfer reset, plus a
// 4-master instance for the pointer-wrap case.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic [1:0]      tr2, wr2;
    logic [2*AW-1:0] ad2;
    logic [2*DW-1:0] wd2;
    logic            rdy2;
    logic            psel2, pwrite2, rsto2;
    logic [AW-1:0]   paddr2;
    logic [DW-1:0]   pdata2;
    logic [1:0]      grant2, stall2;

    logic [3:0]      tr4, wr4;
    logic [4*AW-1:0] ad4;
    logic [4*DW-1:0] wd4;
    logic            rdy4;
    logic            psel4, pwrite4, rsto4;
    logic [AW-1:0]   paddr4;
    logic [DW-1:0]   pdata4;
    logic [3:0]      grant4, stall4;

    mem_arbiter #(.NUM_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) u_dut2 (
        .HCLK(clk), .HRESET(rstn), .HTRANS(tr2), .HADDR(ad2), .HWRITE(wr2),
        .HWDATA(wd2), .PREADY(rdy2), .PSEL(psel2), .PADDR(paddr2),
        .PWRITE(pwrite2), .PDATA(pdata2), .grant(grant2), .stall(stall2),
        .HRESET_o(rsto2)
    );

    mem_arbiter #(.NUM_MASTERS(4), .ADDR_W(AW), .DATA_W(DW)) u_dut4 (
        .HCLK(clk), .HRESET(rstn), .HTRANS(tr4), .HADDR(ad4), .HWRITE(wr4),
        .HWDATA(wd4), .PREADY(rdy4), .PSEL(psel4), .PADDR(paddr4),
        .PWRITE(pwrite4), .PDATA(pdata4), .grant(grant4), .stall(stall4),
        .HRESET_o(rsto4)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  exp_w1, exp_w2;
    logic [31:0] exp_a1;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_w1 = 4'b1000; exp_w2 = 4'b0001; exp_a1 = 32'h0000_4000;
`else
        exp_w1 = 4'b0001; exp_w2 = 4'b1000; exp_a1 = 32'h0000_1000;
`endif
        rstn = 1'b0;
        tr2  = 2'b11;
        wr2  = 2'b10;
        ad2  = {32'h0000_0100, 32'h0000_0200};
        wd2  = {32'h0000_BEEF, 32'h0000_1234};
        rdy2 = 1'b0;
        tr4  = 4'b0000;
        wr4  = 4'b0000;
        ad4  = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        wd4  = '0;
        rdy4 = 1'b0;

        // reset with both masters requesting
        tick(); tick();
        chk("rst_grant", grant2, 2'b00);
        chk("rst_psel", psel2, 1'b0);
        chk("rst_paddr", paddr2, 32'h0);
        chk("rst_stall", stall2, 2'b00);
        chk("rst_fwd", rsto2, 1'b0);
        rstn = 1'b1;
        #1;
        chk("idle_stall", stall2, 2'b11);
        chk("fwd_high", rsto2, 1'b1);
        tick();
        chk("rel_grant", grant2, 2'b01);
        chk("rel_psel", psel2, 1'b1);
        chk("rel_paddr", paddr2, 32'h0000_0200);
        chk("rel_pwrite", pwrite2, 1'b0);
        chk("rel_pdata", pdata2, 32'h0000_1234);

        // contention with PREADY high: alternate without an idle cycle
        rdy2 = 1'b1;
        #1;
        chk("cont_stall0", stall2, 2'b10);
        tick();
        chk("cont_grant2", grant2, 2'b10);
        chk("cont_paddr2", paddr2, 32'h0000_0100);
        chk("cont_pwrite2", pwrite2, 1'b1);
        chk("cont_pdata2", pdata2, 32'h0000_BEEF);
        chk("cont_stall1", stall2, 2'b01);
        tick();
        chk("cont_grant3", grant2, 2'b01);

        // drop requests: complete and go idle; PREADY in IDLE ignored
        tr2 = 2'b00;
        tick();
        chk("drop_grant", grant2, 2'b00);
        chk("drop_psel", psel2, 1'b0);
        chk("drop_paddr", paddr2, 32'h0);
        chk("drop_pdata", pdata2, 32'h0);
        tick();
        chk("idle_rdy_psel", psel2, 1'b0);

        // single master 1
        tr2 = 2'b10;
        #1;
        chk("single_req_stall", stall2, 2'b10);
        tick();
        chk("single_grant", grant2, 2'b10);
        chk("single_paddr", paddr2, 32'h0000_0100);
        chk("single_stall", stall2, 2'b00);
        tr2 = 2'b00;
        tick();
        chk("single_idle", psel2, 1'b0);

        // wait states on master 0, request dropped mid-transfer
        tr2  = 2'b01;
        rdy2 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wait_grant", grant2, 2'b01);
            chk("wait_psel", psel2, 1'b1);
            chk("wait_paddr", paddr2, 32'h0000_0200);
            if (i == 0) chk("wait_stall", stall2, 2'b01);
            if (i == 1) tr2 = 2'b00;
            tick();
        end
        chk("hold_after_drop", grant2, 2'b01);
        rdy2 = 1'b1;
        tick();
        chk("wait_done_psel", psel2, 1'b0);
        chk("wait_done_grant", grant2, 2'b00);

        // mid-transfer reset, then pointer must be back at 0
        tr2  = 2'b01;
        rdy2 = 1'b0;
        tick();
        chk("mid_grant", grant2, 2'b01);
        rstn = 1'b0;
        tr2  = 2'b11;
        #1;
        chk("mid_rst_stall", stall2, 2'b00);
        tick();
        chk("mid_rst_grant", grant2, 2'b00);
        chk("mid_rst_psel", psel2, 1'b0);
        rstn = 1'b1;
        tick();
        chk("post_rst_grant", grant2, 2'b01);
        tr2  = 2'b00;
        rdy2 = 1'b1;
        tick(); tick();

        // four masters: master 2 first, then masters 0 and 3 contend
        tr4  = 4'b0100;
        rdy4 = 1'b1;
        tick();
        chk("n4_grant0", grant4, 4'b0100);
        chk("n4_paddr0", paddr4, 32'h0000_3000);
        tr4 = 4'b1001;
        tick();
        chk("n4_grant1", grant4, exp_w1);
        chk("n4_paddr1", paddr4, exp_a1);
        tick();
        chk("n4_grant2", grant4, exp_w2);
        tr4 = 4'b0000;
        tick(); tick();
        chk("n4_idle", psel4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
